rt_mem_ctrl: RTL and testbench



---
 rtl/rt_mem_ctrl.sv | 289 ++++++++++++++++++++++++++++
 tb/tb_rt_mem_ctrl.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/rt_mem_ctrl.sv
// rt_mem_ctrl: racetrack memory transaction initiator.
// Accepts one OBI-style word request from the core at a time. It shifts the
// track forward to the addressed word, pulses write/read, waits for the
// datapath (bounded by a timeout), shifts back, and returns one response.
// All datapath-facing outputs and response outputs come from flops that are
// loaded from the next-state decode. Only data_gnt_o is combinational.

module rt_mem_ctrl #(
  parameter int ADDR_WIDTH  = 8,
  parameter int DATA_WIDTH  = 32,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  // core side
  input  logic                  data_req_i,
  input  logic [ADDR_WIDTH-1:0] data_addr_i,
  input  logic                  data_we_i,
  input  logic [3:0]            data_be_i,
  input  logic [DATA_WIDTH-1:0] data_wdata_i,
  input  logic [DATA_WIDTH-1:0] data_mask_i,
  input  logic                  data_range_i,
  input  logic [2:0]            data_funct_i,
  output logic                  data_gnt_o,
  output logic                  data_rvalid_o,
  output logic [DATA_WIDTH-1:0] data_rdata_o,
  output logic                  data_err_o,
  // datapath side
  output logic                  en_ab_o,
  output logic [3:0]            be_b_o,
  output logic [ADDR_WIDTH-1:0] addr_o,
  output logic [DATA_WIDTH-1:0] wdata_o,
  output logic                  write_en_data_o,
  output logic [DATA_WIDTH-1:0] mask_o,
  output logic                  range_active_o,
  output logic [2:0]            funct_o,
  output logic                  clk_m_o,
  output logic                  Bz_s_o,
  output logic                  write_pulse_o,
  output logic                  read_pulse_o,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i,
  input  logic                  mem_valid_i
);

  localparam int TMO_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_SHIFT_FWD  = 3'd1,
    S_ACCESS     = 3'd2,
    S_WAIT_RD    = 3'd3,
    S_SHIFT_BACK = 3'd4,
    S_RESP       = 3'd5
  } state_e;

  // FSM and captured request
  state_e                state_q, state_d;
  logic [1:0]            n_q, n_d;          // word index within the port group
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [3:0]            be_q, be_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] mask_q, mask_d;
  logic                  range_q, range_d;
  logic [2:0]            funct_q, funct_d;
  // shift sequencing: phase 0 = pulse-high cycle, phase 1 = pulse-low cycle
  logic                  phase_q, phase_d;
  logic [1:0]            pcnt_q, pcnt_d;
  logic [TMO_W-1:0]      tmo_q, tmo_d;
  logic [DATA_WIDTH-1:0] rd_cap_q, rd_cap_d;
  logic                  err_flag_q, err_flag_d;

  // registered outputs
  logic                  rvalid_q, rvalid_d;
  logic [DATA_WIDTH-1:0] rdata_out_q, rdata_out_d;
  logic                  err_out_q, err_out_d;
  logic                  en_ab_q, en_ab_d;
  logic [3:0]            be_out_q, be_out_d;
  logic [ADDR_WIDTH-1:0] addr_out_q, addr_out_d;
  logic [DATA_WIDTH-1:0] wdata_out_q, wdata_out_d;
  logic                  wen_out_q, wen_out_d;
  logic [DATA_WIDTH-1:0] mask_out_q, mask_out_d;
  logic                  range_out_q, range_out_d;
  logic [2:0]            funct_out_q, funct_out_d;
  logic                  clk_m_q, clk_m_d;
  logic                  bz_q, bz_d;
  logic                  wpulse_q, wpulse_d;
  logic                  rpulse_q, rpulse_d;

  logic                  active_d;
  logic                  shift_d;

  // Grant only while idle and not in reset, so a request is never granted and then dropped.
  assign data_gnt_o = data_req_i & (state_q == S_IDLE) & ~rst_i;

  // Next-state, capture and output decode for the transaction sequencer.
  always_comb begin
    state_d     = state_q;
    n_d         = n_q;
    we_d        = we_q;
    addr_d      = addr_q;
    be_d        = be_q;
    wdata_d     = wdata_q;
    mask_d      = mask_q;
    range_d     = range_q;
    funct_d     = funct_q;
    phase_d     = phase_q;
    pcnt_d      = pcnt_q;
    tmo_d       = tmo_q;
    rd_cap_d    = rd_cap_q;
    err_flag_d  = err_flag_q;

    case (state_q)
      S_IDLE: begin
        if (data_gnt_o) begin
          addr_d     = data_addr_i;
          we_d       = data_we_i;
          be_d       = data_be_i;
          wdata_d    = data_wdata_i;
          mask_d     = data_mask_i;
          range_d    = data_range_i;
          funct_d    = data_funct_i;
          n_d        = data_addr_i[3:2];
          phase_d    = 1'b0;
          pcnt_d     = 2'd0;
          tmo_d      = '0;
          rd_cap_d   = '0;
          err_flag_d = 1'b0;
          state_d    = (data_addr_i[3:2] != 2'd0) ? S_SHIFT_FWD : S_ACCESS;
        end else begin
          state_d = S_IDLE;
        end
      end

      S_SHIFT_FWD, S_SHIFT_BACK: begin
        if (!phase_q) begin
          phase_d = 1'b1;
        end else if (pcnt_q == (n_q - 2'd1)) begin
          // last low phase of the n-th pulse: leave with the counters cleared
          phase_d = 1'b0;
          pcnt_d  = 2'd0;
          state_d = (state_q == S_SHIFT_FWD) ? S_ACCESS : S_RESP;
        end else begin
          phase_d = 1'b0;
          pcnt_d  = pcnt_q + 2'd1;
        end
      end

      S_ACCESS: begin
        if (we_q) begin
          rd_cap_d = '0;
          state_d  = (n_q != 2'd0) ? S_SHIFT_BACK : S_RESP;
        end else begin
          tmo_d   = '0;
          state_d = S_WAIT_RD;
        end
      end

      S_WAIT_RD: begin
        if (mem_valid_i) begin
          // valid takes priority over a simultaneous timeout
          rd_cap_d   = mem_rdata_i;
          err_flag_d = 1'b0;
          state_d    = (n_q != 2'd0) ? S_SHIFT_BACK : S_RESP;
        end else if (tmo_q == TMO_W'(TIMEOUT_CYC - 1)) begin
          rd_cap_d   = '0;
          err_flag_d = 1'b1;
          state_d    = (n_q != 2'd0) ? S_SHIFT_BACK : S_RESP;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end

      S_RESP: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // outputs for the cycle the FSM is about to enter
    active_d    = (state_d != S_IDLE);
    shift_d     = (state_d == S_SHIFT_FWD) || (state_d == S_SHIFT_BACK);
    en_ab_d     = active_d;
    be_out_d    = active_d ? be_d    : 4'd0;
    addr_out_d  = active_d ? addr_d  : '0;
    wdata_out_d = active_d ? wdata_d : '0;
    wen_out_d   = active_d & we_d;
    mask_out_d  = active_d ? mask_d  : '0;
    range_out_d = active_d & range_d;
    funct_out_d = active_d ? funct_d : 3'd0;
    clk_m_d     = shift_d & ~phase_d;
    bz_d        = (state_d == S_SHIFT_FWD);
    wpulse_d    = (state_d == S_ACCESS) & we_d;
    rpulse_d    = (state_d == S_ACCESS) & ~we_d;
    rvalid_d    = (state_d == S_RESP);
    if (state_d == S_RESP) begin
      rdata_out_d = rd_cap_d;
      err_out_d   = err_flag_d;
    end else begin
      rdata_out_d = rdata_out_q;
      err_out_d   = err_out_q;
    end
  end

  // State, captured request and registered outputs; reset drops any transaction.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      n_q         <= 2'd0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      be_q        <= 4'd0;
      wdata_q     <= '0;
      mask_q      <= '0;
      range_q     <= 1'b0;
      funct_q     <= 3'd0;
      phase_q     <= 1'b0;
      pcnt_q      <= 2'd0;
      tmo_q       <= '0;
      rd_cap_q    <= '0;
      err_flag_q  <= 1'b0;
      rvalid_q    <= 1'b0;
      rdata_out_q <= '0;
      err_out_q   <= 1'b0;
      en_ab_q     <= 1'b0;
      be_out_q    <= 4'd0;
      addr_out_q  <= '0;
      wdata_out_q <= '0;
      wen_out_q   <= 1'b0;
      mask_out_q  <= '0;
      range_out_q <= 1'b0;
      funct_out_q <= 3'd0;
      clk_m_q     <= 1'b0;
      bz_q        <= 1'b0;
      wpulse_q    <= 1'b0;
      rpulse_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      n_q         <= n_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      be_q        <= be_d;
      wdata_q     <= wdata_d;
      mask_q      <= mask_d;
      range_q     <= range_d;
      funct_q     <= funct_d;
      phase_q     <= phase_d;
      pcnt_q      <= pcnt_d;
      tmo_q       <= tmo_d;
      rd_cap_q    <= rd_cap_d;
      err_flag_q  <= err_flag_d;
      rvalid_q    <= rvalid_d;
      rdata_out_q <= rdata_out_d;
      err_out_q   <= err_out_d;
      en_ab_q     <= en_ab_d;
      be_out_q    <= be_out_d;
      addr_out_q  <= addr_out_d;
      wdata_out_q <= wdata_out_d;
      wen_out_q   <= wen_out_d;
      mask_out_q  <= mask_out_d;
      range_out_q <= range_out_d;
      funct_out_q <= funct_out_d;
      clk_m_q     <= clk_m_d;
      bz_q        <= bz_d;
      wpulse_q    <= wpulse_d;
      rpulse_q    <= rpulse_d;
    end
  end

  assign data_rvalid_o   = rvalid_q;
  assign data_rdata_o    = rdata_out_q;
  assign data_err_o      = err_out_q;
  assign en_ab_o         = en_ab_q;
  assign be_b_o          = be_out_q;
  assign addr_o          = addr_out_q;
  assign wdata_o         = wdata_out_q;
  assign write_en_data_o = wen_out_q;
  assign mask_o          = mask_out_q;
  assign range_active_o  = range_out_q;
  assign funct_o         = funct_out_q;
  assign clk_m_o         = clk_m_q;
  assign Bz_s_o          = bz_q;
  assign write_pulse_o   = wpulse_q;
  assign read_pulse_o    = rpulse_q;

endmodule

// File: tb/tb_rt_mem_ctrl.sv
// Testbench for rt_mem_ctrl: table-driven single transactions plus
// hand-written sequences for reset mid-transaction and back-to-back requests.
// Cycle 0 of a transaction is its grant cycle; inputs change 1 ns after the
// rising edge and outputs are sampled on the falling edge.

module tb_rt_mem_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        data_req_i;
  logic [7:0]  data_addr_i;
  logic        data_we_i;
  logic [3:0]  data_be_i;
  logic [31:0] data_wdata_i;
  logic [31:0] data_mask_i;
  logic        data_range_i;
  logic [2:0]  data_funct_i;
  logic        data_gnt_o;
  logic        data_rvalid_o;
  logic [31:0] data_rdata_o;
  logic        data_err_o;
  logic        en_ab_o;
  logic [3:0]  be_b_o;
  logic [7:0]  addr_o;
  logic [31:0] wdata_o;
  logic        write_en_data_o;
  logic [31:0] mask_o;
  logic        range_active_o;
  logic [2:0]  funct_o;
  logic        clk_m_o;
  logic        Bz_s_o;
  logic        write_pulse_o;
  logic        read_pulse_o;
  logic [31:0] mem_rdata_i;
  logic        mem_valid_i;

  int pass_cnt  = 0;
  int total_cnt = 0;

  rt_mem_ctrl #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .TIMEOUT_CYC(16)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .data_req_i(data_req_i), .data_addr_i(data_addr_i), .data_we_i(data_we_i),
    .data_be_i(data_be_i), .data_wdata_i(data_wdata_i), .data_mask_i(data_mask_i),
    .data_range_i(data_range_i), .data_funct_i(data_funct_i),
    .data_gnt_o(data_gnt_o), .data_rvalid_o(data_rvalid_o),
    .data_rdata_o(data_rdata_o), .data_err_o(data_err_o),
    .en_ab_o(en_ab_o), .be_b_o(be_b_o), .addr_o(addr_o), .wdata_o(wdata_o),
    .write_en_data_o(write_en_data_o), .mask_o(mask_o),
    .range_active_o(range_active_o), .funct_o(funct_o),
    .clk_m_o(clk_m_o), .Bz_s_o(Bz_s_o),
    .write_pulse_o(write_pulse_o), .read_pulse_o(read_pulse_o),
    .mem_rdata_i(mem_rdata_i), .mem_valid_i(mem_valid_i)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [7:0]  addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] mask;
    logic        range_op;
    logic [2:0]  funct;
    int          vwait;      // WAIT_RD cycles before mem_valid_i; -1 = never
    logic [31:0] mdata;      // value on mem_rdata_i
    int          lat;        // grant cycle to rvalid cycle
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act !== exp)
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    else
      pass_cnt++;
  endtask

  function automatic logic any_output();
    return |{data_gnt_o, data_rvalid_o, data_rdata_o, data_err_o, en_ab_o, be_b_o,
             addr_o, wdata_o, write_en_data_o, mask_o, range_active_o, funct_o,
             clk_m_o, Bz_s_o, write_pulse_o, read_pulse_o};
  endfunction

  // Called 1 ns after a rising edge; returns 1 ns after a rising edge.
  task automatic run_txn(input vec_t v, input int idx);
    int n, acc_cyc, vcyc;
    int fwd, back, en_cnt, rv_cnt, rv_cyc, wp_cnt, rp_cnt, pulse_cyc, extra_gnt;
    logic [31:0] rd, acc_addr, acc_be, acc_wdata, acc_mask, acc_misc;
    logic er;
    n = int'(v.addr[3:2]);
    acc_cyc = 2 * n + 1;
    vcyc = (v.vwait >= 0) ? (2 * n + 2 + v.vwait) : -1;
    fwd = 0; back = 0; en_cnt = 0; rv_cnt = 0; rv_cyc = -1;
    wp_cnt = 0; rp_cnt = 0; pulse_cyc = -1; extra_gnt = 0;
    rd = '0; er = 1'b0;
    acc_addr = '0; acc_be = '0; acc_wdata = '0; acc_mask = '0; acc_misc = '0;
    for (int c = 0; c <= v.lat + 2; c++) begin
      data_req_i = (c == 0);
      if (c == 0) begin
        data_addr_i  = v.addr;
        data_we_i    = v.we;
        data_be_i    = v.be;
        data_wdata_i = v.wdata;
        data_mask_i  = v.mask;
        data_range_i = v.range_op;
        data_funct_i = v.funct;
      end
      mem_valid_i = (c == vcyc);
      mem_rdata_i = v.mdata;
      @(negedge clk_i);
      if (c == 0) check($sformatf("v%0d_gnt", idx), 32'(data_gnt_o), 32'd1);
      else if (data_gnt_o) extra_gnt++;
      if (clk_m_o && Bz_s_o)  fwd++;
      if (clk_m_o && !Bz_s_o) back++;
      if (c >= 1 && en_ab_o) en_cnt++;
      if (write_pulse_o) begin wp_cnt++; pulse_cyc = c; end
      if (read_pulse_o)  begin rp_cnt++; pulse_cyc = c; end
      if (c == acc_cyc) begin
        acc_addr  = 32'(addr_o);
        acc_be    = 32'(be_b_o);
        acc_wdata = wdata_o;
        acc_mask  = mask_o;
        acc_misc  = {27'd0, write_en_data_o, range_active_o, funct_o};
      end
      if (data_rvalid_o) begin
        rv_cnt++; rv_cyc = c; rd = data_rdata_o; er = data_err_o;
      end
      @(posedge clk_i); #1;
    end
    mem_valid_i = 1'b0;
    check($sformatf("v%0d_extra_gnt", idx), 32'(extra_gnt), 32'd0);
    check($sformatf("v%0d_rvalid_cnt", idx), 32'(rv_cnt), 32'd1);
    check($sformatf("v%0d_latency", idx), 32'(rv_cyc), 32'(v.lat));
    check($sformatf("v%0d_rdata", idx), rd, v.exp_rdata);
    check($sformatf("v%0d_err", idx), 32'(er), 32'(v.exp_err));
    check($sformatf("v%0d_fwd_pulses", idx), 32'(fwd), 32'(n));
    check($sformatf("v%0d_back_pulses", idx), 32'(back), 32'(n));
    check($sformatf("v%0d_pulse_cyc", idx), 32'(pulse_cyc), 32'(acc_cyc));
    check($sformatf("v%0d_wp_cnt", idx), 32'(wp_cnt), v.we ? 32'd1 : 32'd0);
    check($sformatf("v%0d_rp_cnt", idx), 32'(rp_cnt), v.we ? 32'd0 : 32'd1);
    check($sformatf("v%0d_en_ab_cycles", idx), 32'(en_cnt), 32'(v.lat));
    check($sformatf("v%0d_addr_o", idx), acc_addr, 32'(v.addr));
    check($sformatf("v%0d_be_b_o", idx), acc_be, 32'(v.be));
    check($sformatf("v%0d_wdata_o", idx), acc_wdata, v.wdata);
    check($sformatf("v%0d_mask_o", idx), acc_mask, v.mask);
    check($sformatf("v%0d_we_range_funct", idx), acc_misc,
          {27'd0, v.we, v.range_op, v.funct});
  endtask

  initial begin
    int gcnt, g2, rv_n, rv1_cyc, rv2_cyc;
    logic [31:0] rv1_d, rv2_d;
    logic rv2_e;
    vec_t w;

    //        addr   we    be     wdata         mask          rng   fn    vw  mdata         lat exp_rdata     err
    vecs[0] = '{8'h00, 1'b0, 4'hF, 32'h0,        32'hFFFFFFFF, 1'b0, 3'd0,  0, 32'hA5A5A5A5,  3, 32'hA5A5A5A5, 1'b0};
    vecs[1] = '{8'h0C, 1'b1, 4'hF, 32'h12345678, 32'h0000FFFF, 1'b1, 3'd5, -1, 32'h77777777, 14, 32'h0,        1'b0};
    vecs[2] = '{8'h08, 1'b0, 4'hF, 32'h0,        32'h0F0F0000, 1'b0, 3'd2, -1, 32'h5A5A5A5A, 26, 32'h0,        1'b1};
    vecs[3] = '{8'h04, 1'b0, 4'hC, 32'h0,        32'h000000FF, 1'b1, 3'd7, 15, 32'hDEADBEEF, 22, 32'hDEADBEEF, 1'b0};
    vecs[4] = '{8'h0D, 1'b0, 4'h2, 32'h0,        32'h80000001, 1'b0, 3'd1,  1, 32'h0F0F0F0F, 16, 32'h0F0F0F0F, 1'b0};
    vecs[5] = '{8'h01, 1'b1, 4'h1, 32'hAABBCCDD, 32'h0,        1'b0, 3'd3, -1, 32'h0,         2, 32'h0,        1'b0};
    vecs[6] = '{8'h06, 1'b0, 4'hF, 32'h0,        32'h12340000, 1'b1, 3'd4, 14, 32'h13572468, 21, 32'h13572468, 1'b0};

    rst_i = 1'b1;
    data_req_i = 1'b0; data_addr_i = '0; data_we_i = 1'b0; data_be_i = '0;
    data_wdata_i = '0; data_mask_i = '0; data_range_i = 1'b0; data_funct_i = '0;
    mem_rdata_i = '0; mem_valid_i = 1'b0;

    // reset state
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    check("reset_outputs_zero", 32'(any_output()), 32'd0);
    @(posedge clk_i); #1;
    rst_i = 1'b0;

    for (int i = 0; i < 7; i++) run_txn(vecs[i], i);

    // reset during SHIFT_FWD of an n = 3 read
    gcnt = 0; rv_n = 0;
    data_req_i = 1'b1; data_addr_i = 8'h0C; data_we_i = 1'b0; data_be_i = 4'hF;
    data_mask_i = 32'hFFFF0000; data_range_i = 1'b1; data_funct_i = 3'd6;
    @(negedge clk_i);
    if (data_gnt_o) gcnt++;
    @(posedge clk_i); #1;
    data_req_i = 1'b0;
    @(negedge clk_i);
    check("rst_seq_in_shift_fwd", {30'd0, clk_m_o, Bz_s_o}, 32'd3);
    @(posedge clk_i); #1;
    rst_i = 1'b1;                           // asserted in the 2nd SHIFT_FWD cycle
    @(negedge clk_i);
    @(posedge clk_i); #1;
    @(negedge clk_i);
    check("rst_seq_gnt", 32'(gcnt), 32'd1);
    check("rst_mid_outputs_zero", 32'(any_output()), 32'd0);
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    w = '{8'h02, 1'b1, 4'h3, 32'hCAFEBABE, 32'h0000000F, 1'b0, 3'd1, -1, 32'h0, 2, 32'h0, 1'b0};
    run_txn(w, 100);                        // granted in the first cycle out of reset

    // req held high across two requests, spurious mem_valid_i while idle
    gcnt = 0; g2 = -1; rv_n = 0; rv1_cyc = -1; rv2_cyc = -1;
    rv1_d = '0; rv2_d = '0; rv2_e = 1'b1;
    for (int c = 0; c <= 16; c++) begin
      data_req_i = (c <= 4);
      if (c == 0) begin data_addr_i = 8'h00; data_we_i = 1'b0; end
      if (c == 4) begin data_addr_i = 8'h04; data_we_i = 1'b0; end
      mem_valid_i = (c == 2) || (c == 4) || (c == 10);
      mem_rdata_i = (c == 2) ? 32'h0BADF00D : ((c == 4) ? 32'h11111111 : 32'hCAFE0001);
      @(negedge clk_i);
      if (data_gnt_o) begin gcnt++; g2 = c; end
      if (data_rvalid_o) begin
        rv_n++;
        if (rv_n == 1) begin rv1_cyc = c; rv1_d = data_rdata_o; end
        else begin rv2_cyc = c; rv2_d = data_rdata_o; rv2_e = data_err_o; end
      end
      @(posedge clk_i); #1;
    end
    mem_valid_i = 1'b0;
    check("b2b_gnt_count", 32'(gcnt), 32'd2);
    check("b2b_second_gnt_cyc", 32'(g2), 32'd4);
    check("b2b_rvalid_count", 32'(rv_n), 32'd2);
    check("b2b_rv1_cyc", 32'(rv1_cyc), 32'd3);
    check("b2b_rv1_data", rv1_d, 32'h0BADF00D);
    check("b2b_rv2_cyc", 32'(rv2_cyc), 32'd13);
    check("b2b_rv2_data", rv2_d, 32'hCAFE0001);
    check("b2b_rv2_err", 32'(rv2_e), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
